// File: rtl/apb_slave_mem_pkg.sv
// Shared types and constants for the APB slave memory: FSM states, latched
// request payload and pselx decode helpers.
package apb_slave_pkg;

    localparam int unsigned NUM_BANKS = 3;
    localparam int unsigned OFFSET_W  = 12;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned BANK_W    = 2;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_e;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic              write;
        logic              err;
    } req_t;

    function automatic logic [BANK_W-1:0] bank_of(input logic [NUM_BANKS-1:0] sel);
        if (sel[2])      return BANK_W'(2);
        else if (sel[1]) return BANK_W'(1);
        else             return BANK_W'(0);
    endfunction

    function automatic logic is_onehot(input logic [NUM_BANKS-1:0] sel);
        return (sel != '0) && ((sel & (sel - NUM_BANKS'(1))) == '0);
    endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB completer-side bus bundle seen by apb_slave_mem.
interface apb_slave_mem_if;
    import apb_slave_pkg::*;

    logic [NUM_BANKS-1:0] pselx;
    logic                 penable;
    logic                 pwrite;
    logic [ADDR_W-1:0]    paddr;
    logic [DATA_W-1:0]    pwdata;
    logic [DATA_W-1:0]    prdata;
    logic                 pready;
    logic                 pslverr;

    modport slave  (input  pselx, penable, pwrite, paddr, pwdata,
                    output prdata, pready, pslverr);
    modport master (output pselx, penable, pwrite, paddr, pwdata,
                    input  prdata, pready, pslverr);
endinterface

// File: rtl/apb_slave_mem_bank.sv
// One word-addressed storage bank: reset-cleared array, synchronous write,
// combinational read.
module apb_mem_bank
    import apb_slave_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with three one-hot-selected memory banks and a fixed number
// of wait states per access.
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic            hclk,
    input  logic            hreset,
    apb_slave_mem_if.slave  apb
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic [AW-1:0]     word_q, word_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;

    logic              setup_c, abort_c, err_c, commit_c;
    logic [BANK_W-1:0] bank_c;
    logic [AW-1:0]     word_c;
    logic [DATA_W-1:0] rd_sel_c;
    logic [DATA_W-1:0] rd_data [NUM_BANKS];
    logic              unused_paddr;

    assign bank_c   = bank_of(apb.pselx);
    assign word_c   = apb.paddr[AW+1:2];
    assign err_c    = !is_onehot(apb.pselx)
                   || (apb.paddr[1:0] != 2'b00)
                   || (apb.paddr[OFFSET_W-1:0] >= OFFSET_W'(DEPTH * 4));
    assign setup_c  = (state_q == IDLE) && (apb.pselx != '0) && !apb.penable;
    assign abort_c  = (state_q != IDLE) && (!apb.penable || (apb.pselx == '0));
    assign commit_c = (state_q == READY) && !abort_c && req_q.write && !req_q.err;
    assign unused_paddr = ^apb.paddr[ADDR_W-1:OFFSET_W];

    // Read port is addressed by the live setup address so prdata loads on the setup edge
    always_comb begin
        rd_sel_c = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            if (bank_c == BANK_W'(b)) rd_sel_c = rd_data[b];
        end
    end

    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
        apb_mem_bank #(.DEPTH(DEPTH)) u_bank (
            .clk   (hclk),
            .rst_n (hreset),
            .we    (commit_c && (req_q.bank == BANK_W'(b))),
            .waddr (word_q),
            .wdata (apb.pwdata),
            .raddr (word_c),
            .rdata (rd_data[b])
        );
    end

    always_ff @(posedge hclk or negedge hreset) begin
        if (!hreset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= '0;
            word_q   <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            word_q   <= word_d;
            prdata_q <= prdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (setup_c) state_d = (WAIT_CYCLES > 0) ? WAIT : READY;
            WAIT:    if (abort_c) state_d = IDLE;
                     else if (cnt_q == CNT_W'(1)) state_d = READY;
            READY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, wait counter and read data register
    always_comb begin
        cnt_d    = cnt_q;
        req_d    = req_q;
        word_d   = word_q;
        prdata_d = prdata_q;
        if (setup_c) begin
            req_d.bank  = bank_c;
            req_d.write = apb.pwrite;
            req_d.err   = err_c;
            word_d      = word_c;
            cnt_d       = CNT_W'(WAIT_CYCLES);
            if (!apb.pwrite) prdata_d = err_c ? '0 : rd_sel_c;
        end else if ((state_q == WAIT) && !abort_c) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        if (state_q == READY) begin
            apb.pready  = 1'b1;
            apb.pslverr = req_q.err;
        end
    end

    assign apb.prdata = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with no wait states and one
// with three, both driven from the same APB stimulus.
module tb_apb_slave_mem;

    logic        hclk;
    logic        hreset;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    int passed = 0;
    int total  = 0;

    apb_slave_mem_if if0 ();
    apb_slave_mem_if if3 ();

    assign if0.pselx = pselx;   assign if3.pselx = pselx;
    assign if0.penable = penable; assign if3.penable = penable;
    assign if0.pwrite = pwrite; assign if3.pwrite = pwrite;
    assign if0.paddr = paddr;   assign if3.paddr = paddr;
    assign if0.pwdata = pwdata; assign if3.pwdata = pwdata;

    apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (.hclk(hclk), .hreset(hreset), .apb(if0));
    apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(3)) u_dut3 (.hclk(hclk), .hreset(hreset), .apb(if3));

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic idle(input int n);
        pselx = 3'b000;
        penable = 1'b0;
        repeat (n) begin
            @(posedge hclk);
            #1;
        end
    endtask

    // Runs one transfer starting just after a rising edge; returns at completing edge + 1.
    task automatic xfer(input logic [2:0] sel, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input bit on3,
                        output logic [31:0] rd, output logic err, output int waits);
        bit done;
        pselx = sel; paddr = addr; pwrite = wr; pwdata = wd; penable = 1'b0;
        @(posedge hclk); #1;
        penable = 1'b1;
        waits = 0; done = 1'b0; rd = 'x; err = 1'bx;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge hclk);
            if ((on3 ? if3.pready : if0.pready) === 1'b1) begin
                rd   = on3 ? if3.prdata : if0.prdata;
                err  = on3 ? if3.pslverr : if0.pslverr;
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge hclk); #1;
        end
        if (!done) begin
            total++;
            $display("FAIL xfer_timeout: sel=%b addr=%h got no pready want pready within 20 cycles", sel, addr);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic err; int w; int bad;
        pselx = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        hreset = 1'b0;
        #2;
        total++;
        if ({if0.prdata, if0.pready, if0.pslverr} !== 34'h0)
            $display("FAIL reset_hold_dut0: got %h/%b/%b want 0/0/0", if0.prdata, if0.pready, if0.pslverr);
        else passed++;
        #2 hreset = 1'b1;
        @(posedge hclk); #1;
        total++;
        if ({if0.prdata, if0.pready, if0.pslverr} !== 34'h0)
            $display("FAIL reset_release_dut0: got %h/%b/%b want 0/0/0", if0.prdata, if0.pready, if0.pslverr);
        else passed++;
        total++;
        if ({if3.prdata, if3.pready, if3.pslverr} !== 34'h0)
            $display("FAIL reset_release_dut3: got %h/%b/%b want 0/0/0", if3.prdata, if3.pready, if3.pslverr);
        else passed++;
        for (int b = 0; b < 3; b++) begin
            bad = 0;
            for (int i = 0; i < 16; i++) begin
                xfer(3'(1 << b), 32'(i * 4), 1'b0, '0, 1'b0, rd, err, w);
                if (rd !== 32'h0 || err !== 1'b0) bad++;
            end
            total++;
            if (bad != 0) $display("FAIL reset_bank%0d_zero: got %0d nonzero/errored words want 0", b, bad);
            else passed++;
        end
        idle(1);
    endtask

    task automatic test_wr_rd_wait0();
        logic [31:0] rd; logic err; int w;
        xfer(3'b010, 32'h8, 1'b1, 32'hDEAD_BEEF, 1'b0, rd, err, w);
        total++;
        if (w !== 0 || err !== 1'b0) $display("FAIL w0_write: got waits=%0d err=%b want 0/0", w, err);
        else passed++;
        xfer(3'b010, 32'h8, 1'b0, '0, 1'b0, rd, err, w);
        total++;
        if (w !== 0) $display("FAIL w0_read_waits: got %0d want 0", w);
        else passed++;
        total++;
        if (rd !== 32'hDEAD_BEEF || err !== 1'b0) $display("FAIL w0_read_data: got %h err=%b want deadbeef/0", rd, err);
        else passed++;
        xfer(3'b001, 32'h8, 1'b0, '0, 1'b0, rd, err, w);
        total++;
        if (rd !== 32'h0) $display("FAIL w0_bank0_untouched: got %h want 00000000", rd);
        else passed++;
        xfer(3'b100, 32'h8, 1'b0, '0, 1'b0, rd, err, w);
        total++;
        if (rd !== 32'h0) $display("FAIL w0_bank2_untouched: got %h want 00000000", rd);
        else passed++;
        idle(2);
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic err; int w;
        xfer(3'b100, 32'h0, 1'b1, 32'hCAFE_0002, 1'b1, rd, err, w);
        total++;
        if (w !== 3) $display("FAIL ws_write_waits: got %0d want 3", w);
        else passed++;
        idle(1);
        pselx = 3'b100; paddr = 32'h0; pwrite = 1'b0; penable = 1'b0;
        @(posedge hclk); #1;
        penable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge hclk);
            total++;
            if (if3.pready !== 1'b0 || if3.prdata !== 32'hCAFE_0002)
                $display("FAIL ws_wait_cycle%0d: got pready=%b prdata=%h want 0/cafe0002", c, if3.pready, if3.prdata);
            else passed++;
            @(posedge hclk); #1;
        end
        @(negedge hclk);
        total++;
        if (if3.pready !== 1'b1 || if3.prdata !== 32'hCAFE_0002 || if3.pslverr !== 1'b0)
            $display("FAIL ws_ready_cycle: got pready=%b prdata=%h err=%b want 1/cafe0002/0", if3.pready, if3.prdata, if3.pslverr);
        else passed++;
        @(posedge hclk); #1;
        idle(2);
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int w;
        xfer(3'b010, 32'h8, 1'b0, '0, 1'b0, rd, err, w);
        xfer(3'b011, 32'h0, 1'b0, '0, 1'b0, rd, err, w);
        total++;
        if (err !== 1'b1 || rd !== 32'h0) $display("FAIL err_multisel: got err=%b prdata=%h want 1/00000000", err, rd);
        else passed++;
        idle(1);
        @(negedge hclk);
        total++;
        if (if0.pslverr !== 1'b0) $display("FAIL err_idle_pslverr: got %b want 0", if0.pslverr);
        else passed++;
        @(posedge hclk); #1;
        xfer(3'b010, 32'h8, 1'b0, '0, 1'b0, rd, err, w);
        xfer(3'b001, 32'h42, 1'b0, '0, 1'b0, rd, err, w);
        total++;
        if (err !== 1'b1 || rd !== 32'h0) $display("FAIL err_misaligned: got err=%b prdata=%h want 1/00000000", err, rd);
        else passed++;
        xfer(3'b001, 32'h0, 1'b1, 32'h0000_AAAA, 1'b0, rd, err, w);
        xfer(3'b001, 32'h40, 1'b1, 32'h1234_5678, 1'b0, rd, err, w);
        total++;
        if (err !== 1'b1) $display("FAIL err_range_write: got err=%b want 1", err);
        else passed++;
        xfer(3'b001, 32'h0, 1'b0, '0, 1'b0, rd, err, w);
        total++;
        if (rd !== 32'h0000_AAAA || err !== 1'b0) $display("FAIL err_range_nocommit: got %h err=%b want 0000aaaa/0", rd, err);
        else passed++;
        idle(2);
    endtask

    task automatic test_incr8();
        logic [31:0] rd; logic err; int w;
        logic [31:0] vals [8];
        vals = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008, 32'h4444_000C,
                 32'h5555_0010, 32'h6666_0014, 32'h7777_0018, 32'h8888_001C};
        for (int i = 0; i < 8; i++) xfer(3'b001, 32'(i * 4), 1'b1, vals[i], 1'b0, rd, err, w);
        for (int i = 0; i < 8; i++) begin
            xfer(3'b001, 32'(i * 4), 1'b0, '0, 1'b0, rd, err, w);
            total++;
            if (rd !== vals[i] || err !== 1'b0 || w !== 0)
                $display("FAIL incr8_beat%0d: got %h err=%b waits=%0d want %h/0/0", i, rd, err, w, vals[i]);
            else passed++;
        end
        idle(2);
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int w;
        pselx = 3'b010; paddr = 32'h4; pwrite = 1'b1; pwdata = 32'h5555_5555; penable = 1'b0;
        @(posedge hclk); #1;
        penable = 1'b1;
        @(negedge hclk);
        total++;
        if (if3.pready !== 1'b0) $display("FAIL abort_wait_pready: got %b want 0", if3.pready);
        else passed++;
        @(posedge hclk); #1;
        penable = 1'b0;
        @(posedge hclk); #1;
        @(negedge hclk);
        total++;
        if (if3.pready !== 1'b0 || if3.pslverr !== 1'b0) $display("FAIL abort_idle: got pready=%b err=%b want 0/0", if3.pready, if3.pslverr);
        else passed++;
        idle(1);
        xfer(3'b010, 32'h4, 1'b0, '0, 1'b1, rd, err, w);
        total++;
        if (w !== 3 || rd !== 32'h0 || err !== 1'b0)
            $display("FAIL abort_nocommit: got waits=%0d prdata=%h err=%b want 3/00000000/0", w, rd, err);
        else passed++;
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int w;
        xfer(3'b001, 32'h4, 1'b0, '0, 1'b0, rd, err, w);
        pselx = 3'b100; paddr = 32'hC; pwrite = 1'b1; pwdata = 32'h7777_7777; penable = 1'b0;
        @(posedge hclk); #1;
        penable = 1'b1;
        @(negedge hclk);
        total++;
        if (if0.pready !== 1'b1 || if0.prdata !== 32'h2222_0004)
            $display("FAIL rstmid_ready: got pready=%b prdata=%h want 1/22220004", if0.pready, if0.prdata);
        else passed++;
        #1 hreset = 1'b0;
        #1;
        total++;
        if ({if0.prdata, if0.pready, if0.pslverr} !== 34'h0)
            $display("FAIL rstmid_async: got %h/%b/%b want 0/0/0", if0.prdata, if0.pready, if0.pslverr);
        else passed++;
        @(posedge hclk); #1;
        hreset = 1'b1;
        idle(1);
        xfer(3'b100, 32'hC, 1'b0, '0, 1'b0, rd, err, w);
        total++;
        if (rd !== 32'h0 || err !== 1'b0) $display("FAIL rstmid_nocommit: got %h err=%b want 00000000/0", rd, err);
        else passed++;
        idle(1);
    endtask

    initial begin
        test_reset();
        test_wr_rd_wait0();
        test_wait_states();
        test_errors();
        test_incr8();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer that sits directly downstream of `apb_interface` and provides the bus endpoint behind the bridge. It decodes the three one-hot `pselx` lines into three independent word-addressed memory banks, and it inserts a parameterised number of wait states. It returns `prdata`, `pready` and `pslverr`, so bridge and master read/write bursts terminate on real storage instead of a stub.

## Interface
- `DEPTH`, 16: words per bank; power of two, 4 to 256.
- `WAIT_CYCLES`, 0: wait states per access, 0 to 15. The current bridge does not sample `pready`, so it requires 0.
- `hclk`  in  1  bus clock; all state changes on the rising edge.
- `hreset`  in  1  asynchronous, active-low reset.
- `pselx`  in  3  one-hot bank select; bit n selects bank n.
- `penable`  in  1  APB access-phase strobe.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  32  byte address; bits [11:0] are the bank offset.
- `pwdata`  in  32  write data.
- `prdata`  out  32  read data; registered.
- `pready`  out  1  transfer completes on the edge where it is high.
- `pslverr`  out  1  error response; valid only while `pready` is high.

## Operation
- The FSM has three states: IDLE, WAIT and READY.
- Setup is detected in IDLE when any `pselx` bit is high and `penable` is low. On that edge the block latches:
  - bank index;
  - word index `paddr[log2(DEPTH)+1:2]`;
  - `pwrite`;
  - error flag.
- The error flag is set on any of:
  - `pselx` not exactly one-hot;
  - `paddr[1:0]` not equal to 0;
  - `paddr[11:0]` ≥ DEPTH×4.
- For reads, `prdata` loads on the setup edge:
  - selected word when the error flag is clear;
  - 32'h0 when it is set.
- `prdata` holds its value until the next read setup. Writes never change it.
- State transitions:
  - IDLE to WAIT on setup when `WAIT_CYCLES` > 0; a counter loads `WAIT_CYCLES`.
  - IDLE to READY on setup when `WAIT_CYCLES` = 0.
  - WAIT: the counter decrements each cycle while `penable` is high. At count 1 the FSM moves to READY.
  - READY to IDLE unconditionally after one cycle.
- `pready` = (state == READY), combinational from the state register.
- `pslverr` = latched error flag AND `pready`.
- A write commits `pwdata` into the latched bank and word on the READY edge, only if the error flag is clear and `penable` is high. An errored write leaves memory unchanged.
- Abandoned transfer: `penable` low or `pselx` all zero while in WAIT or READY returns the FSM to IDLE. No write commits and no error is reported.
- The three banks are independent. A write to bank n never alters banks m ≠ n.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - `prdata` 32'h0;
  - `pready` 0;
  - `pslverr` 0;
  - all memory words 32'h0.
- Reset asserted mid-transfer aborts the transfer immediately, with no write commit. Outputs return to their reset values asynchronously.
- Transfer length from the setup edge to the completing edge is `WAIT_CYCLES`+1 access cycles. With `WAIT_CYCLES` = 0, `pready` is high in the first access cycle.
- Read data is valid from the first access cycle, so read and write latency are identical.
- Back-to-back transfers: the cycle after READY is IDLE, which accepts the next setup with no extra bubble beyond APB's mandatory setup phase.
- A read that immediately follows a write to the same word returns the new data, because the write commits before the next setup edge.

## Structure
- Package `apb_slave_pkg` holds:
  - state enum (IDLE=2'd0, WAIT=2'd1, READY=2'd2);
  - `NUM_BANKS`=3;
  - `OFFSET_W`=12.
- Sub-module `apb_mem_bank` is instantiated three times. Each instance provides:
  - DEPTH×32 register array with reset clear;
  - one synchronous write port;
  - one combinational read port.
- The top level owns the FSM, wait counter, decode, error logic and output mux.

## Test plan
- Reset: hold `hreset`=0 for 4 ns, then release → `prdata`=0, `pready`=0, `pslverr`=0, and every word of every bank reads 0.
- Write/read, `WAIT_CYCLES`=0: write 32'hDEAD_BEEF to bank 1 at `paddr`=32'h0000_0008, then read it back → `pready` high in the first access cycle of each transfer, `prdata`=32'hDEAD_BEEF, `pslverr`=0. Bank 0 and bank 2 at offset 8 still read 0.
- Wait states, `WAIT_CYCLES`=3: a read of bank 2 offset 0 holds `pready` low for 3 access cycles and high on the 4th. `prdata` is stable throughout.
- Errors:
  - `pselx`=3'b011 → `pslverr`=1 with `prdata`=0;
  - `paddr`=32'h0000_0042 → `pslverr`=1 with `prdata`=0;
  - a write to `paddr`=32'h0000_0040 with DEPTH=16 → `pslverr`=1 and memory unchanged.
- INCR8 burst: the bridge issues 8 consecutive writes to bank 0 at offsets 0x0 to 0x1C, followed by 8 reads → the reads return the written values in order, with no dropped or duplicated beats.
- Abort and reset: drop `penable` during WAIT → no commit and the FSM returns to IDLE. Assert `hreset` low in READY of a write → the word stays 0 and all outputs are 0 immediately.
